// File: rtl/boreal_ads_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : boreal_ads_pkg
// Brief   : Shared constants, state encoding and helpers for the ADS1299-style
//           frame responder (ADC-side SPI slave model).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package boreal_ads_pkg;

    // Every word on the wire (status and channel samples) is 24 bits wide
    localparam int ADS_WORD_W = 24;

    // Status word placed ahead of the channel data in each frame
    localparam logic [ADS_WORD_W-1:0] ADS_STATUS_WORD_DEFAULT = 24'hC00000;

    // Responder protocol states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ads_state_t;

    // Total serial bits in one frame: status word plus one word per channel
    function automatic int frame_bits(input int nch);
        return ADS_WORD_W * (nch + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : spi_edge_sync
// Brief   : Two-flop synchronizer for an asynchronous SPI pin followed by
//           registered single-cycle rise/fall pulses in the clk domain.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module spi_edge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Synchronize the pin, remember the previous level and register edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ads_frame_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ads_frame_responder
// Brief   : ADC-side model of an ADS1299-style front end. Periodically latches
//           a sample frame, signals DRDY and shifts the frame out on MISO in
//           SPI mode 1, MSB first. Samples arrive through a one-entry
//           valid/ready holding buffer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module ads_frame_responder
    import boreal_ads_pkg::*;
#(
    parameter int                     NCH         = 8,
    parameter int                     SAMPLE_DIV  = 400000,
    parameter logic [ADS_WORD_W-1:0]  STATUS_WORD = ADS_STATUS_WORD_DEFAULT,
    parameter int                     CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_valid,
    input  logic [NCH*ADS_WORD_W-1:0] sample_data,
    output logic                      sample_ready,
    input  logic                      ads_sclk,
    input  logic                      ads_cs_n,
    output logic                      ads_drdy_n,
    output logic                      ads_miso,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic [CNT_W-1:0]          underrun_cnt,
    output logic [CNT_W-1:0]          overrun_cnt
);

    localparam int c_DATA_W     = NCH * ADS_WORD_W;
    localparam int c_FRAME_BITS = frame_bits(NCH);
    localparam int c_BITCNT_W   = $clog2(c_FRAME_BITS + 1);
    localparam int c_DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [c_BITCNT_W-1:0] c_FB_CNT   = c_BITCNT_W'(c_FRAME_BITS);
    localparam logic [c_DIV_W-1:0]    c_DIV_LAST = c_DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]      c_CNT_MAX  = {CNT_W{1'b1}};

    // Synchronized SPI edge strobes
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (ads_sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // CS idles high, so its synchronizer comes out of reset deasserted
    spi_edge_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (ads_cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // State and datapath registers
    ads_state_t                 r_state;
    ads_state_t                 w_state_nxt;
    logic [c_DIV_W-1:0]         r_div;
    logic [c_DATA_W-1:0]        r_buf;
    logic                       r_buf_empty;
    logic [c_FRAME_BITS-1:0]    r_shift;
    logic [c_FRAME_BITS-1:0]    r_last;
    logic [c_BITCNT_W-1:0]      r_bitcnt;
    logic                       r_drdy_n;
    logic                       r_miso;
    logic                       r_frame_done;
    logic                       r_frame_abort;
    logic [CNT_W-1:0]           r_underrun;
    logic [CNT_W-1:0]           r_overrun;

    // Control strobes from the state machine
    logic                       w_tick;
    logic                       w_drdy_nxt;
    logic                       w_miso_nxt;
    logic                       w_done;
    logic                       w_abort;
    logic                       w_load;
    logic                       w_shift_en;
    logic                       w_bit_clr;
    logic                       w_ovr;

    // Frame-load source selection
    logic                       w_from_buf;
    logic                       w_bypass;
    logic                       w_underrun;
    logic                       w_accept;
    logic [c_FRAME_BITS-1:0]    w_load_frame;

    assign w_tick     = (r_div == c_DIV_LAST);
    assign w_accept   = sample_valid & r_buf_empty;
    assign w_from_buf = w_load & ~r_buf_empty;
    assign w_bypass   = w_load & r_buf_empty & sample_valid;
    assign w_underrun = w_load & r_buf_empty & ~sample_valid;

    // A full buffer wins; otherwise same-cycle input data; otherwise repeat
    assign w_load_frame = w_from_buf ? {STATUS_WORD, r_buf} :
                          w_bypass   ? {STATUS_WORD, sample_data} :
                                       r_last;

    // Sample-rate divider producing a one-cycle tick every SAMPLE_DIV clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; chip-select edges take priority over
    // ticks, and any tick that cannot load a frame counts as an overrun
    always_comb begin
        w_state_nxt = r_state;
        w_drdy_nxt  = r_drdy_n;
        w_miso_nxt  = r_miso;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        w_bit_clr   = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            IDLE: begin
                w_drdy_nxt = 1'b1;
                if (w_cs_fall) begin
                    w_state_nxt = SHIFT;
                    w_bit_clr   = 1'b1;
                    w_ovr       = w_tick;
                end else if (w_tick) begin
                    w_load      = 1'b1;
                    w_drdy_nxt  = 1'b0;
                    w_state_nxt = READY;
                end
            end
            READY: begin
                // A tick here blips DRDY high for exactly one cycle
                w_drdy_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_state_nxt = SHIFT;
                    w_bit_clr   = 1'b1;
                    w_ovr       = w_tick;
                end else if (w_tick) begin
                    w_ovr      = 1'b1;
                    w_load     = 1'b1;
                    w_drdy_nxt = 1'b1;
                end
            end
            SHIFT: begin
                w_ovr = w_tick;
                if (w_cs_rise) begin
                    w_abort     = (r_bitcnt < c_FB_CNT);
                    w_miso_nxt  = 1'b0;
                    w_drdy_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    if (w_sclk_rise) begin
                        if (r_bitcnt < c_FB_CNT) begin
                            w_miso_nxt = r_shift[c_FRAME_BITS-1];
                            w_shift_en = 1'b1;
                        end else begin
                            w_miso_nxt = 1'b0;
                        end
                    end
                    if (w_sclk_fall) begin
                        w_drdy_nxt = 1'b1;
                        if (r_bitcnt == c_FB_CNT) begin
                            w_done      = 1'b1;
                            w_state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                w_ovr = w_tick;
                if (w_sclk_rise) begin
                    w_miso_nxt = 1'b0;
                end
                if (w_cs_rise) begin
                    w_miso_nxt  = 1'b0;
                    w_drdy_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Holding buffer, frame shifter, bit counter, outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf         <= '0;
            r_buf_empty   <= 1'b1;
            r_shift       <= {STATUS_WORD, {c_DATA_W{1'b0}}};
            r_last        <= {STATUS_WORD, {c_DATA_W{1'b0}}};
            r_bitcnt      <= '0;
            r_drdy_n      <= 1'b1;
            r_miso        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_underrun    <= '0;
            r_overrun     <= '0;
        end else begin
            if (w_from_buf) begin
                r_buf_empty <= 1'b1;
            end else if (w_accept && !w_load) begin
                r_buf       <= sample_data;
                r_buf_empty <= 1'b0;
            end

            if (w_load) begin
                r_shift <= w_load_frame;
                r_last  <= w_load_frame;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[c_FRAME_BITS-2:0], 1'b0};
            end

            if (w_bit_clr) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            r_drdy_n      <= w_drdy_nxt;
            r_miso        <= w_miso_nxt;
            r_frame_done  <= w_done;
            r_frame_abort <= w_abort;

            if (w_underrun && (r_underrun != c_CNT_MAX)) begin
                r_underrun <= r_underrun + 1'b1;
            end
            if (w_ovr && (r_overrun != c_CNT_MAX)) begin
                r_overrun <= r_overrun + 1'b1;
            end
        end
    end

    assign sample_ready = r_buf_empty;
    assign ads_drdy_n   = r_drdy_n;
    assign ads_miso     = r_miso;
    assign frame_done   = r_frame_done;
    assign frame_abort  = r_frame_abort;
    assign underrun_cnt = r_underrun;
    assign overrun_cnt  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ads_frame_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_ads_frame_responder
// Brief   : Directed self-checking bench for ads_frame_responder with a small
//           SPI master (SCLK = clk/8) sampling MISO on the falling edge.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_ads_frame_responder;

    localparam int NCH        = 2;
    localparam int SAMPLE_DIV = 1000;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic [NCH*24-1:0] sample_data;
    logic              sample_ready;
    logic              ads_sclk;
    logic              ads_cs_n;
    logic              ads_drdy_n;
    logic              ads_miso;
    logic              frame_done;
    logic              frame_abort;
    logic [CNT_W-1:0]  underrun_cnt;
    logic [CNT_W-1:0]  overrun_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;
    int          n_abort  = 0;
    int unsigned cyc      = 0;
    int unsigned t_rel    = 0;

    ads_frame_responder #(
        .NCH        (NCH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .STATUS_WORD(24'hC00000),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .ads_sclk     (ads_sclk),
        .ads_cs_n     (ads_cs_n),
        .ads_drdy_n   (ads_drdy_n),
        .ads_miso     (ads_miso),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count high cycles of the pulse outputs
    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [NCH*24-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_drdy_low(input string tag, output int unsigned at);
        bit to;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!ads_drdy_n) begin
                to = 1'b0;
                break;
            end
        end
        at = cyc;
        check_eq(tag, 72'(to), 72'd0);
    endtask

    task automatic spi_read(input int nbits, input bit release_cs,
                            output logic [71:0] data, output logic drdy_b, output logic drdy_a);
        data   = '0;
        drdy_b = 1'b1;
        drdy_a = 1'b1;
        ads_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            ads_sclk = 1'b1;
            repeat (4) @(negedge clk);
            data = {data[70:0], ads_miso};
            if (b == 0) drdy_b = ads_drdy_n;
            ads_sclk = 1'b0;
            repeat (4) @(negedge clk);
            if (b == 0) drdy_a = ads_drdy_n;
        end
        if (release_cs) begin
            ads_cs_n = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        logic [71:0]  rd;
        logic [71:0]  exp_b;
        logic         db;
        logic         da;
        int unsigned  t;
        int unsigned  target;
        int           nh;
        bit           to;

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        ads_sclk     = 1'b0;
        ads_cs_n     = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        check_eq("rst_drdy_n",   72'(ads_drdy_n),   72'd1);
        check_eq("rst_miso",     72'(ads_miso),     72'd0);
        check_eq("rst_ready",    72'(sample_ready), 72'd1);
        check_eq("rst_underrun", 72'(underrun_cnt), 72'd0);
        check_eq("rst_overrun",  72'(overrun_cnt),  72'd0);
        check_eq("rst_pulses",   72'({frame_done, frame_abort}), 72'd0);

        rst   = 1'b0;
        t_rel = cyc;

        // 1: basic frame
        push({24'h123456, 24'hABCDEF});
        check_eq("t1_ready_full", 72'(sample_ready), 72'd0);
        wait_drdy_low("t1_drdy_wait", t);
        check_eq("t1_first_tick", 72'(t - t_rel), 72'd1000);
        check_eq("t1_ready_after", 72'(sample_ready), 72'd1);
        spi_read(72, 1'b1, rd, db, da);
        check_eq("t1_data", rd, 72'hC00000_123456_ABCDEF);
        check_eq("t1_drdy_before_fall", 72'(db), 72'd0);
        check_eq("t1_drdy_after_fall",  72'(da), 72'd1);
        check_eq("t1_done_cnt", 72'(n_done), 72'd1);
        check_eq("t1_underrun", 72'(underrun_cnt), 72'd0);

        // 2: no new sample, frame repeats
        wait_drdy_low("t2_drdy_wait", t);
        check_eq("t2_tick_time", 72'(t - t_rel), 72'd2000);
        check_eq("t2_underrun", 72'(underrun_cnt), 72'd1);
        check_eq("t2_ready", 72'(sample_ready), 72'd1);
        spi_read(72, 1'b1, rd, db, da);
        check_eq("t2_data", rd, 72'hC00000_123456_ABCDEF);
        check_eq("t2_done_cnt", 72'(n_done), 72'd2);

        // 3: unread frame overwritten by the next tick
        push({24'h111111, 24'h222222});
        wait_drdy_low("t3_drdy_wait", t);
        push({24'h3C5A69, 24'h96A5C3});
        check_eq("t3_ready_full", 72'(sample_ready), 72'd0);
        to = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (ads_drdy_n) begin
                to = 1'b0;
                break;
            end
        end
        check_eq("t3_drdy_blip_seen", 72'(to), 72'd0);
        nh = 0;
        while (ads_drdy_n && nh < 10) begin
            nh++;
            @(negedge clk);
        end
        check_eq("t3_drdy_high_cycles", 72'(nh), 72'd1);
        check_eq("t3_overrun", 72'(overrun_cnt), 72'd1);
        check_eq("t3_ready_after", 72'(sample_ready), 72'd1);
        spi_read(72, 1'b1, rd, db, da);
        check_eq("t3_data", rd, 72'hC00000_3C5A69_96A5C3);
        check_eq("t3_underrun", 72'(underrun_cnt), 72'd1);

        // 4: abort after 30 bits, then a normal frame
        exp_b = 72'hC00000_3C5A69_96A5C3;
        wait_drdy_low("t4_drdy_wait", t);
        check_eq("t4_underrun", 72'(underrun_cnt), 72'd2);
        spi_read(30, 1'b1, rd, db, da);
        check_eq("t4_partial_data", 72'(rd[29:0]), 72'(exp_b[71:42]));
        check_eq("t4_abort_cycles", 72'(n_abort), 72'd1);
        check_eq("t4_no_done", 72'(n_done), 72'd3);
        check_eq("t4_drdy_n", 72'(ads_drdy_n), 72'd1);
        check_eq("t4_miso", 72'(ads_miso), 72'd0);
        push({24'hFEDCBA, 24'h012345});
        wait_drdy_low("t4_drdy_wait2", t);
        spi_read(72, 1'b1, rd, db, da);
        check_eq("t4_data_after", rd, 72'hC00000_FEDCBA_012345);
        check_eq("t4_done_cnt", 72'(n_done), 72'd4);

        // 6: sample offered exactly in the tick cycle with the buffer empty
        target = t_rel + 32'd7000 - 32'd1;
        for (int i = 0; i < 3000 && cyc != target; i++) @(negedge clk);
        check_eq("t6_align", 72'(cyc), 72'(target));
        check_eq("t6_ready_before", 72'(sample_ready), 72'd1);
        push({24'h0F1E2D, 24'h3C4B5A});
        check_eq("t6_drdy_n", 72'(ads_drdy_n), 72'd0);
        check_eq("t6_underrun", 72'(underrun_cnt), 72'd2);
        check_eq("t6_ready_after", 72'(sample_ready), 72'd1);
        spi_read(72, 1'b1, rd, db, da);
        check_eq("t6_data", rd, 72'hC00000_0F1E2D_3C4B5A);
        check_eq("t6_done_cnt", 72'(n_done), 72'd5);

        // 5: reset in the middle of a transfer
        wait_drdy_low("t5_drdy_wait", t);
        check_eq("t5_underrun_pre", 72'(underrun_cnt), 72'd3);
        spi_read(10, 1'b0, rd, db, da);
        rst      = 1'b1;
        ads_cs_n = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        t_rel = cyc;
        check_eq("t5_drdy_n", 72'(ads_drdy_n), 72'd1);
        check_eq("t5_miso", 72'(ads_miso), 72'd0);
        check_eq("t5_counters", 72'({underrun_cnt, overrun_cnt}), 72'd0);
        check_eq("t5_ready", 72'(sample_ready), 72'd1);
        wait_drdy_low("t5_drdy_wait2", t);
        check_eq("t5_first_tick", 72'(t - t_rel), 72'd1000);
        check_eq("t5_no_abort", 72'(n_abort), 72'd1);
        check_eq("t5_underrun_post", 72'(underrun_cnt), 72'd1);
        spi_read(72, 1'b1, rd, db, da);
        check_eq("t5_data", rd, 72'hC00000_000000_000000);
        check_eq("t5_done_cnt", 72'(n_done), 72'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
